hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage RISC-V core; it works alongside the forwarding unit to cover the hazards that forwarding cannot resolve. It detects load-use hazards, flushes on taken branches, and sequences the multi-cycle mul/div unit in Execute. While that unit runs, the controller holds the front end and injects bubbles into Memory. All stall and flush outputs are Mealy outputs, valid in the same cycle as the hazard they respond to.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_perf_cnt.sv | 26 ++
 rtl/hazard_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The state enum, the mul/div latency default and the NOP encodings used when flushing pipeline registers.
package hazard_pkg;

  typedef enum logic {
    HZ_RUN     = 1'b0,
    HZ_MD_WAIT = 1'b1
  } hz_state_e;

  localparam int unsigned HZ_MD_CYCLES_DEF = 32;

  // addi x0, x0, 0: the canonical RISC-V NOP loaded into flushed IF/ID and ID/EX registers
  localparam logic [31:0] HZ_NOP_INSTR = 32'h0000_0013;
  localparam logic [4:0]  HZ_NOP_RD    = 5'd0;

  function automatic int unsigned hz_cnt_w(input int unsigned md_cycles);
    return $clog2(md_cycles + 1);
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Enabled wrap-around event counter with asynchronous clear.
// Only present when HAZARD_PERF_CNT_EN is defined.
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// Load-use / branch / multi-cycle mul-div hazard controller for the 5-stage core; stalls and flushes are Mealy.
// Optional performance counters (StallCnt, FlushCnt, MdCnt) are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MD_CYCLES = HZ_MD_CYCLES_DEF,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       RS1D,
  input  logic [4:0]       RS2D,
  input  logic [4:0]       RDE,
  input  logic             RegWriteE,
  input  logic             LoadE,
  input  logic             MdOpE,
  input  logic             PCSrcE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             BubbleM,
  output logic             MdStart,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic [CNT_W-1:0] MdCnt,
`endif
  output logic             MdBusy
);

  localparam int unsigned CW = hz_cnt_w(MD_CYCLES);

  if (MD_CYCLES < 1 || CNT_W < 1) begin : g_param_chk
    $error("hazard_ctrl: MD_CYCLES and CNT_W must be at least 1");
  end

  hz_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            lw_stall, md_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HZ_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MdOpE is only sampled in RUN, so the op still sitting in Execute on its final cycle is not restarted
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      HZ_RUN: begin
        if (MdOpE) begin
          state_d = HZ_MD_WAIT;
          cnt_d   = CW'(MD_CYCLES - 1);
        end
      end
      HZ_MD_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = HZ_RUN;
        end
      end
      default: state_d = HZ_RUN;
    endcase
  end

  // Outputs are forced low while reset is held, whatever the inputs
  always_comb begin
    lw_stall = LoadE & RegWriteE & (RDE != 5'd0) & ((RDE == RS1D) | (RDE == RS2D));
    md_stall = ((state_q == HZ_RUN) & MdOpE) | ((state_q == HZ_MD_WAIT) & (cnt_q != '0));

    StallF  = rst_n & (lw_stall | md_stall);
    StallD  = rst_n & (lw_stall | md_stall);
    StallE  = rst_n & md_stall;
    BubbleM = rst_n & md_stall;
    FlushD  = rst_n & PCSrcE & ~md_stall;
    FlushE  = rst_n & (lw_stall | PCSrcE) & ~md_stall;
    MdStart = rst_n & (state_q == HZ_RUN) & MdOpE;
    MdBusy  = (state_q == HZ_MD_WAIT);
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (StallF),
    .cnt_o (StallCnt)
  );

  hazard_perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (FlushE),
    .cnt_o (FlushCnt)
  );

  hazard_perf_cnt #(.W(CNT_W)) u_md_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (MdStart),
    .cnt_o (MdCnt)
  );
`endif

endmodule
